rob_completion_arbiter: RTL
===========================

# rob_completion_arbiter

Shares the ROB's single completion write port among several execution units. Each cycle it grants one valid requester in round-robin order, registers the winner's ROB tag and result, and drives the ROB completion write port one cycle later. On a pipeline restore it drops all in-flight and pending completions, so stale results are never written into a freshly reset ROB.

## Interface
- NUM_REQ, 4: number of completing execution units (≥2).
- ROB_ADDR_W, 5: ROB tag width. It is addrSize+1; tags are 1-based and 0 means "no entry".
- DATA_W, 70: completion payload width.
- EXTRA_W, 64: extra completion payload width.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- needToRestore_i  in  1  flush; same signal the ROB receives.
- req_valid_i  in  NUM_REQ  per-unit completion request.
- req_ready_o  out  NUM_REQ  one-hot grant, combinational.
- req_addr_i  in  NUM_REQ*ROB_ADDR_W  packed tags; unit k occupies slice [k*ROB_ADDR_W +: ROB_ADDR_W].
- req_data_i  in  NUM_REQ*DATA_W  packed payloads.
- req_extra_i  in  NUM_REQ*EXTRA_W  packed extra payloads.
- completionWriteEn_o  out  1  ROB completion write enable.
- completionWriteAddr_o  out  ROB_ADDR_W  ROB tag.
- completionWriteData_o  out  DATA_W  payload.
- completionWriteDataExtra_o  out  EXTRA_W  extra payload.
- grant_id_o  out  $clog2(NUM_REQ)  unit index of the current write.
- tag_err_o  out  1  sticky: a request with tag 0 was granted.

## Operation
- State:
  - rr_ptr: $clog2(NUM_REQ) bits, priority start index.
  - Output register: en, addr, data, extra, id.
  - tag_err: sticky flag.
- Arbitration is combinational in each cycle.
  - Winner: the first k with req_valid_i[k]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready_o has exactly the winner's bit set. It is all-zero if no request is valid or needToRestore_i=1.
- Handshake: a unit holds req_valid_i and its payload stable until it sees req_ready_o[k]=1 in the same cycle. The transfer completes on that edge. Valid must not depend on ready.
- On a grant edge:
  - Output register loads the winner's tag, data and extra; en=1; id=k.
  - rr_ptr becomes (k+1) mod NUM_REQ, so it wraps from NUM_REQ-1 to 0.
- On an edge with no grant: en=0, payload registers hold their value, rr_ptr holds.
- A granted tag of 0 is still accepted (ready=1) but is not written: en=0 next cycle, and tag_err is set until reset.
- Flush (needToRestore_i=1 at an edge):
  - No grant; en cleared to 0.
  - rr_ptr reset to 0. tag_err is unaffected.
  - A pending unit stays un-acked; the unit itself must drop valid on restore.
- The ROB port always accepts, so there is no backpressure from the ROB. Throughput is one completion per cycle.

## Timing
- Reset (reset_n_i=0, asynchronous): all outputs 0, rr_ptr=0, tag_err=0. Effect is immediate, mid-transfer included; a grant in flight is lost.
- Latency: request granted in cycle t, so completionWriteEn_o=1 with its data in cycle t+1. The ROB samples it at the end of t+1.
- A unit asserting valid every cycle alongside N-1 other always-valid units is granted exactly once every NUM_REQ cycles, so waiting is bounded at NUM_REQ-1 cycles.
- Flush asserted in cycle t:
  - Completion registered at the end of t-1 is still visible during t, alongside the ROB's own restore.
  - completionWriteEn_o=0 in t+1.
- Deassertion of reset_n_i is assumed synchronised externally; the first grant is possible in the first cycle after release.

## Test plan
- Single unit: valid only on unit 2 with tag 5, data 0x3A.
  - req_ready_o=0100 in the same cycle.
  - Next cycle: WriteEn=1, Addr=5, Data=0x3A, grant_id=2.
  - rr_ptr becomes 3.
- All four units valid continuously from reset:
  - Grants run 0,1,2,3,0,1 on consecutive cycles, with one write per cycle.
  - grant_id_o follows the same sequence, one cycle late.
- Wrap and skip: rr_ptr=3, units 1 and 3 valid.
  - Grant 3 first, then 1.
  - rr_ptr goes 3→0→2.
- Flush: units 0 and 1 valid, needToRestore_i pulses in the cycle unit 1 would win.
  - req_ready_o=0000 during the flush cycle.
  - WriteEn=0 the next cycle; rr_ptr=0 afterwards.
  - Unit 0 wins first once requests resume.
- Tag 0: unit 1 requests with tag 0.
  - ready asserted, no write next cycle.
  - tag_err_o=1 and stays set through a flush.
- Async reset mid-stream: drop reset_n_i between clock edges while writes stream.
  - All outputs are 0 immediately, without waiting for an edge.
  - After release, arbitration restarts at unit 0.

Source files
------------

// File: rtl/rob_completion_arbiter.sv
// rob_completion_arbiter
// Round-robin arbiter that shares the ROB's single completion write port
// among NUM_REQ execution units. The winner's tag and payload are registered
// and presented to the ROB one cycle after the grant. A pipeline restore
// drops the pending grant and clears the registered write enable.
module rob_completion_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ROB_ADDR_W = 5,
    parameter int DATA_W     = 70,
    parameter int EXTRA_W    = 64,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          needToRestore_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ROB_ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    input  logic [NUM_REQ*EXTRA_W-1:0]    req_extra_i,
    output logic                          completionWriteEn_o,
    output logic [ROB_ADDR_W-1:0]         completionWriteAddr_o,
    output logic [DATA_W-1:0]             completionWriteData_o,
    output logic [EXTRA_W-1:0]            completionWriteDataExtra_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          tag_err_o
);

    logic [ID_W-1:0]       rr_ptr_reg;
    logic [ID_W-1:0]       rr_ptr_next;
    logic                  en_reg;
    logic [ROB_ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0]     data_reg;
    logic [EXTRA_W-1:0]    extra_reg;
    logic [ID_W-1:0]       id_reg;
    logic                  tag_err_reg;

    logic                  win_found;
    logic [ID_W-1:0]       win_idx;
    logic                  grant_valid;
    int                    cand;

    logic [ROB_ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]     data_arr  [NUM_REQ];
    logic [EXTRA_W-1:0]    extra_arr [NUM_REQ];

    logic [ROB_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [EXTRA_W-1:0]    sel_extra;

    // Unpack the flat request buses and build the one-hot grant vector.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]    = req_addr_i[gi*ROB_ADDR_W +: ROB_ADDR_W];
            assign data_arr[gi]    = req_data_i[gi*DATA_W +: DATA_W];
            assign extra_arr[gi]   = req_extra_i[gi*EXTRA_W +: EXTRA_W];
            assign req_ready_o[gi] = grant_valid && (win_idx == ID_W'(gi));
        end
    endgenerate

    // Round-robin search: scan offsets from the far end down so the valid
    // requester closest to rr_ptr is the last one written, i.e. the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(rr_ptr_reg) + i) % NUM_REQ;
            if (req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(cand);
            end
        end
    end

    // No grant during a restore; reset is folded in so every output is 0
    // while reset is held, even though the grant path is combinational.
    assign grant_valid = win_found && !needToRestore_i && reset_n_i;

    assign sel_addr  = addr_arr[win_idx];
    assign sel_data  = data_arr[win_idx];
    assign sel_extra = extra_arr[win_idx];

    // Priority restarts just past the winner, wrapping from NUM_REQ-1 to 0.
    assign rr_ptr_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Arbitration pointer and sticky zero-tag flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_reg  <= '0;
            tag_err_reg <= 1'b0;
        end else if (needToRestore_i) begin
            rr_ptr_reg  <= '0;
        end else if (grant_valid) begin
            rr_ptr_reg <= rr_ptr_next;
            if (sel_addr == '0) begin
                tag_err_reg <= 1'b1;
            end
        end
    end

    // Completion output register: a tag-0 grant is consumed but not written.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            extra_reg <= '0;
            id_reg    <= '0;
        end else if (grant_valid) begin
            en_reg    <= (sel_addr != '0);
            addr_reg  <= sel_addr;
            data_reg  <= sel_data;
            extra_reg <= sel_extra;
            id_reg    <= win_idx;
        end else begin
            en_reg    <= 1'b0;
        end
    end

    assign completionWriteEn_o        = en_reg;
    assign completionWriteAddr_o      = addr_reg;
    assign completionWriteData_o      = data_reg;
    assign completionWriteDataExtra_o = extra_reg;
    assign grant_id_o                 = id_reg;
    assign tag_err_o                  = tag_err_reg;

endmodule
